// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified-memory port arbiter.
package mem_arb_pkg;

    localparam int unsigned LAT_CNT_W = 4;

    localparam logic OWNER_CPU = 1'b0;
    localparam logic OWNER_LDR = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } arb_state_e;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational two-way requester picker: fixed CPU priority or alternate on conflict.
module mem_arb_pick
    import mem_arb_pkg::*;
#(
    parameter int unsigned CPU_PRIORITY = 0
) (
    input  logic cpu_req,
    input  logic ldr_req,
    input  logic last_grant,
    output logic grant_valid,
    output logic grant_owner
);

    always_comb begin
        grant_valid = cpu_req | ldr_req;
        grant_owner = OWNER_CPU;
        if (cpu_req && ldr_req) begin
            // On conflict the side that did not win last time goes next
            grant_owner = (CPU_PRIORITY != 0) ? OWNER_CPU : ~last_grant;
        end else if (ldr_req) begin
            grant_owner = OWNER_LDR;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single-ported unified memory between the CPU and the loader/debug port,
// sequencing each access over a fixed latency and returning a one-cycle ack.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W       = 16,
    parameter int unsigned DATA_W       = 16,
    parameter int unsigned MEM_LAT      = 2,
    parameter int unsigned CPU_PRIORITY = 0
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ack,
    output logic              cpu_stall,
    input  logic              ldr_req,
    input  logic              ldr_we,
    input  logic [ADDR_W-1:0] ldr_addr,
    input  logic [DATA_W-1:0] ldr_wdata,
    output logic [DATA_W-1:0] ldr_rdata,
    output logic              ldr_ack,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              grant_owner
);

    arb_state_e           state_q, state_d;
    logic [LAT_CNT_W-1:0] cnt_q, cnt_d;
    logic                 owner_q, owner_d;
    logic                 last_q, last_d;
    logic                 we_q, we_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [DATA_W-1:0]    wdata_q, wdata_d;
    logic [DATA_W-1:0]    cpu_rdata_q, cpu_rdata_d;
    logic [DATA_W-1:0]    ldr_rdata_q, ldr_rdata_d;
    logic                 pick_valid;
    logic                 pick_owner;

    mem_arb_pick #(
        .CPU_PRIORITY (CPU_PRIORITY)
    ) u_pick (
        .cpu_req     (cpu_req),
        .ldr_req     (ldr_req),
        .last_grant  (last_q),
        .grant_valid (pick_valid),
        .grant_owner (pick_owner)
    );

    // State and datapath registers
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            owner_q     <= OWNER_CPU;
            last_q      <= OWNER_LDR;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cpu_rdata_q <= '0;
            ldr_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            owner_q     <= owner_d;
            last_q      <= last_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cpu_rdata_q <= cpu_rdata_d;
            ldr_rdata_q <= ldr_rdata_d;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        owner_d     = owner_q;
        last_d      = last_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        cpu_rdata_d = cpu_rdata_q;
        ldr_rdata_d = ldr_rdata_q;
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d = ACCESS;
                    cnt_d   = LAT_CNT_W'(MEM_LAT);
                    owner_d = pick_owner;
                    last_d  = pick_owner;
                    if (pick_owner == OWNER_LDR) begin
                        we_d    = ldr_we;
                        addr_d  = ldr_addr;
                        wdata_d = ldr_wdata;
                    end else begin
                        we_d    = cpu_we;
                        addr_d  = cpu_addr;
                        wdata_d = cpu_wdata;
                    end
                end
            end
            ACCESS: begin
                cnt_d = cnt_q - LAT_CNT_W'(1);
                if (cnt_q == LAT_CNT_W'(1)) begin
                    state_d = DONE;
                    if (!we_q) begin
                        if (owner_q == OWNER_LDR) begin
                            ldr_rdata_d = mem_rdata;
                        end else begin
                            cpu_rdata_d = mem_rdata;
                        end
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy        = (state_q != IDLE);
    assign mem_en      = (state_q == ACCESS);
    assign mem_we      = mem_en & we_q;
    assign mem_addr    = addr_q;
    assign mem_wdata   = wdata_q;
    assign cpu_ack     = (state_q == DONE) && (owner_q == OWNER_CPU);
    assign ldr_ack     = (state_q == DONE) && (owner_q == OWNER_LDR);
    assign cpu_rdata   = cpu_rdata_q;
    assign ldr_rdata   = ldr_rdata_q;
    assign grant_owner = owner_q;
    // Combinational so the control FSM holds without an extra cycle
    assign cpu_stall   = cpu_req & ~cpu_ack;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-ported 16-bit unified memory between two requesters:
  - the processor core, which issues fetch, lw and sw accesses from the multicycle control FSM;
  - the program loader/debug port, which writes programs and peeks memory.
- Sequences each access over a fixed memory latency and returns a one-cycle ack with read data.
- Drives cpu_stall so the control FSM holds its current state while a CPU access is pending.

Parameters:
ADDR_W, 16, address width in words
DATA_W, 16, data width
MEM_LAT, 2, memory access cycles (legal range 1..15)
CPU_PRIORITY, 0, 0 = round-robin on conflict; 1 = CPU always wins conflicts

Ports:
CLK  in  1  clock
Reset  in  1  synchronous active-high reset
cpu_req  in  1  CPU access request, level
cpu_we  in  1  1 = write, 0 = read
cpu_addr  in  ADDR_W  CPU address
cpu_wdata  in  DATA_W  CPU write data
cpu_rdata  out  DATA_W  CPU read data, valid with cpu_ack
cpu_ack  out  1  one-cycle completion pulse to CPU
cpu_stall  out  1  cpu_req and not cpu_ack (combinational)
ldr_req  in  1  loader request, level
ldr_we  in  1  loader write enable
ldr_addr  in  ADDR_W  loader address
ldr_wdata  in  DATA_W  loader write data
ldr_rdata  out  DATA_W  loader read data, valid with ldr_ack
ldr_ack  out  1  one-cycle completion pulse to loader
mem_en  out  1  memory enable
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data, valid in last ACCESS cycle
busy  out  1  state is not IDLE
grant_owner  out  1  0 = CPU, 1 = loader; last or current owner

Behaviour:
Reset (synchronous):
- state = IDLE.
- All outputs 0, including rdata registers and grant_owner.
- last_grant = LDR, so the CPU wins the first conflict.
- Reset mid-transaction abandons the access. No ack is issued. A write already presented is not guaranteed committed.

FSM IDLE -> ACCESS -> DONE -> IDLE:
- IDLE:
  - No req: stay in IDLE, mem_en = 0.
  - On any req: pick an owner, latch that requester's we/addr/wdata into internal registers, load the counter with MEM_LAT, go to ACCESS.
- ACCESS:
  - mem_en = 1. mem_we/mem_addr/mem_wdata come from the latched registers and are stable for all MEM_LAT cycles.
  - The counter decrements each cycle.
  - In the last cycle (counter = 1), a read captures mem_rdata into the owner's rdata register. Go to DONE.
- DONE:
  - mem_en = 0. The owner's ack = 1 for exactly this cycle. Go to IDLE.

Latency:
- req sampled in IDLE at cycle t -> ack at t + MEM_LAT + 1.
- Minimum spacing between acks is MEM_LAT + 2 cycles.

Handshake:
- The requester holds req, we, addr and wdata until ack.
- req still high in the cycle after ack is a new request. Its fields must already be updated on the ack-cycle edge.
- Requester fields are ignored outside the IDLE sampling cycle, because they are latched.
- Deasserting req before ack is illegal. The arbiter completes the access anyway and still pulses ack.

Arbitration (IDLE only):
- Single req: that requester is granted.
- Both req, CPU_PRIORITY = 0: the requester not equal to last_grant wins. Each requester waits at most one foreign transaction.
- Both req, CPU_PRIORITY = 1: the CPU wins. The loader may starve, and this is intended for run mode.
- last_grant and grant_owner update on entry to ACCESS.

Data rules:
- Writes leave both rdata registers unchanged.
- Each rdata register holds its value until that requester's next read completes.

cpu_stall:
- 1 from cpu_req rise through the cycle before cpu_ack.
- 0 during the cpu_ack cycle.
- Combinational, so the control FSM sees no extra latency.

Decomposition:
- Package mem_arb_pkg:
  - state encoding: IDLE = 0, ACCESS = 1, DONE = 2, 2-bit;
  - OWNER_CPU = 0, OWNER_LDR = 1;
  - latency counter width = 4.
- One natural sub-module: mem_arb_pick.
  - Combinational 2-way picker: inputs cpu_req, ldr_req, last_grant, CPU_PRIORITY; outputs grant_valid, grant_owner.
  - Reused later for register-file port sharing.

Test Plan:
- MEM_LAT = 2, CPU read: cpu_req at t, addr 0x0010, memory holds 0xBEEF -> mem_en on t+1..t+2; cpu_ack at t+3 with cpu_rdata = 0xBEEF; cpu_stall high t..t+2, low at t+3.
- Loader write then CPU read: loader write 0x1234 to 0x0020, then CPU read of 0x0020 -> mem_we = 1 only during loader ACCESS; CPU read returns 0x1234; ldr_rdata remains 0x0000.
- Simultaneous req, CPU_PRIORITY = 0, both held for 4 transactions -> grant order CPU, LDR, CPU, LDR; acks every 4 cycles.
- Same stimulus, CPU_PRIORITY = 1 -> all 4 grants go to the CPU; ldr_ack never pulses.
- Reset asserted in the 2nd ACCESS cycle of a CPU read -> next cycle: state IDLE, mem_en = 0, cpu_ack = 0, rdata = 0; a fresh cpu_req then completes normally in 3 cycles.
- Back-to-back CPU reads with req held high and addr changed on the ack edge (0x0001 then 0x0002) -> second access presents mem_addr = 0x0002; acks 4 cycles apart.
